div_issue_ctrl: RTL

- EX-stage initiator for the multi-cycle divider.
- Turns a DIV/DIVU instruction in EX into the divider's start/annul handshake and holds the operands stable for the whole operation.
- Raises the pipeline stall request until the result arrives, then presents HI/LO write-back.
- Aborts cleanly on pipeline flush, and never issues a division twice while a downstream stall holds EX.

---
 rtl/div_issue_ctrl_pkg.sv | 19 +
 rtl/div_issue_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings and constants for the divider issue controller.
package div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    DIVC_IDLE = 2'b00,
    DIVC_BUSY = 2'b01,
    DIVC_DONE = 2'b10
  } divc_state_e;

  localparam logic        DIVSTART          = 1'b1;
  localparam logic        DIVSTOP           = 1'b0;
  localparam logic        DIVRESULTREADY    = 1'b1;
  localparam logic        DIVRESULTNOTREADY = 1'b0;
  localparam logic [31:0] ZEROWORD          = 32'h0000_0000;

  localparam int          BUSY_CNT_W   = 6;
  localparam logic [5:0]  BUSY_CNT_MAX = 6'd63;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider: issues start/annul,
// holds operands for the whole operation, stalls the pipe until the
// result arrives and then presents the HI/LO write-back.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int READY_GUARD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_req_i,
  input  logic                  div_signed_req_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
  output logic                  div_start_o,
  output logic                  div_annul_o,
  output logic                  div_signed_o,
  output logic [DATA_W-1:0]     div_opdata1_o,
  output logic [DATA_W-1:0]     div_opdata2_o,
  input  logic [2*DATA_W-1:0]   div_result_i,
  input  logic                  div_ready_i,
  output logic                  stallreq_o,
  output logic                  hilo_we_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o
);

  // Guard threshold in counter width; ready seen earlier is a leftover
  // from an annulled operation and must be ignored.
  localparam logic [BUSY_CNT_W-1:0] GUARD_CNT = BUSY_CNT_W'(READY_GUARD);

  divc_state_e             state_q;
  divc_state_e             state_d;
  logic [BUSY_CNT_W-1:0]   busy_cnt_q;
  logic                    signed_q;
  logic [DATA_W-1:0]       op1_q;
  logic [DATA_W-1:0]       op2_q;
  logic [DATA_W-1:0]       hi_q;
  logic [DATA_W-1:0]       lo_q;
  logic                    issue;
  logic                    accept;

  assign issue  = (state_q == DIVC_IDLE) & div_req_i & ~flush_i;
  assign accept = (state_q == DIVC_BUSY) & ~flush_i
                & (div_ready_i == DIVRESULTREADY)
                & (busy_cnt_q >= GUARD_CNT);

  // Operands come straight from the latches so they never move while busy
  assign div_signed_o  = signed_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;

  // Write-back values are only visible while the result is being presented
  assign hi_o = (state_q == DIVC_DONE) ? hi_q : ZEROWORD;
  assign lo_o = (state_q == DIVC_DONE) ? lo_q : ZEROWORD;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIVC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Busy-cycle counter: cleared while idle, counts up saturating while busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt_q <= '0;
    end else if (state_q == DIVC_IDLE) begin
      busy_cnt_q <= '0;
    end else if ((state_q == DIVC_BUSY) && (busy_cnt_q != BUSY_CNT_MAX)) begin
      busy_cnt_q <= busy_cnt_q + 1'b1;
    end
  end

  // Capture operands and signedness at issue; the divider re-reads them at fix-up
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signed_q <= 1'b0;
      op1_q    <= ZEROWORD;
      op2_q    <= ZEROWORD;
    end else if (issue) begin
      signed_q <= div_signed_req_i;
      op1_q    <= reg1_i;
      op2_q    <= reg2_i;
    end
  end

  // Capture {remainder, quotient} when an acceptable ready arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= ZEROWORD;
      lo_q <= ZEROWORD;
    end else if (accept) begin
      hi_q <= div_result_i[2*DATA_W-1:DATA_W];
      lo_q <= div_result_i[DATA_W-1:0];
    end
  end

  // Next-state and handshake outputs; flush outranks ready and stall
  always_comb begin
    state_d     = state_q;
    div_start_o = DIVSTOP;
    div_annul_o = 1'b0;
    stallreq_o  = 1'b0;
    hilo_we_o   = 1'b0;
    case (state_q)
      DIVC_IDLE: begin
        // rst gating keeps the combinational stall request quiet in reset
        stallreq_o = rst & div_req_i & ~flush_i;
        if (issue) begin
          state_d = DIVC_BUSY;
        end
      end
      DIVC_BUSY: begin
        stallreq_o = 1'b1;
        if (flush_i) begin
          div_annul_o = 1'b1;
          state_d     = DIVC_IDLE;
        end else begin
          div_start_o = DIVSTART;
          if (accept) begin
            state_d = DIVC_DONE;
          end
        end
      end
      DIVC_DONE: begin
        // start low here lets the divider fall back to free before any reissue
        hilo_we_o = ~flush_i;
        if (flush_i) begin
          state_d = DIVC_IDLE;
        end else if (stall_i) begin
          state_d = DIVC_DONE;
        end else begin
          state_d = DIVC_IDLE;
        end
      end
      default: begin
        state_d = DIVC_IDLE;
      end
    endcase
  end

endmodule
